// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the writeback request record.
package rf_pkg;
  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus: NREQ packed valid/ready lanes carrying rd and data.
interface regfile_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;

  modport master (output req_valid, req_rd, req_data, input req_ready);
  modport slave  (input req_valid, req_rd, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter; with WB_FIXED_PRIO_EN defined it is a fixed-priority encoder (req 0 highest).
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int GW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [GW-1:0]   gnt_idx,
  output logic            gnt_any,
  output logic [GW-1:0]   ptr_nxt
);

`ifdef WB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    ptr_nxt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt      = '0;
        gnt[k]   = 1'b1;
        gnt_idx  = GW'(k);
        gnt_any  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    ptr_nxt = ptr;
    idx     = 0;
    // Scan starting at ptr, wrapping at NREQ; first valid wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx] && !gnt_any) begin
        gnt[idx] = 1'b1;
        gnt_idx  = GW'(idx);
        gnt_any  = 1'b1;
      end
    end
    if (gnt_any)
      ptr_nxt = (gnt_idx == GW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with RAW scoreboard. Build option: WB_FIXED_PRIO_EN.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_wb_arbiter_if.slave      wb,
  output logic [AW-1:0]            rf_rd,
  output logic [XLEN-1:0]          rf_WriteData,
  output logic                     rf_RegWrite,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  input  logic [AW-1:0]            rs1,
  input  logic [AW-1:0]            rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0]   ptr;
  logic [GW-1:0]   ptr_nxt;
  logic [GW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  wb_req_t         sel;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req     (wb.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any),
    .ptr_nxt (ptr_nxt)
  );

  // Ready is masked while reset is held so no handshake completes in reset.
  assign wb.req_ready = reset ? gnt : '0;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == GW'(i)) begin
        sel.rd   = wb.req_rd[i*AW +: AW];
        sel.data = wb.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Write port stage: granted request appears on rf_* one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      grant_id     <= '0;
      rf_rd        <= '0;
      rf_WriteData <= '0;
      rf_RegWrite  <= 1'b0;
    end else if (gnt_any) begin
      ptr          <= ptr_nxt;
      grant_id     <= gnt_idx;
      rf_rd        <= sel.rd;
      rf_WriteData <= sel.data;
      rf_RegWrite  <= (sel.rd != REG_ZERO);
    end else begin
      rf_RegWrite  <= 1'b0;
    end
  end

  // Set after clear so a new producer overrides a completing write.
  always_comb begin
    busy_nxt = busy;
    if (rf_RegWrite)
      busy_nxt[rf_rd] = 1'b0;
    if (issue_valid && (issue_rd != REG_ZERO))
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int NREQ = 2;
  localparam int GW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_WriteData;
  logic            rf_RegWrite;
  logic [GW-1:0]   grant_id;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (bus.slave),
    .rf_rd        (rf_rd),
    .rf_WriteData (rf_WriteData),
    .rf_RegWrite  (rf_RegWrite),
    .grant_id     (grant_id),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy)
  );

`ifdef WB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference state: what the write port and scoreboard should hold now.
  int              m_ptr;
  int              m_gid;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;
  logic            m_we;
  bit              m_busy [NREG];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_gid = 0; m_rd = '0; m_data = '0; m_we = 1'b0;
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_rd[i*AW +: AW]     = rd;
    bus.req_data[i*XLEN +: XLEN] = d;
  endtask

  function automatic int pick();
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = FIXED ? k : (m_ptr + k) % NREQ;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Check every output against the model, then advance the model across one clock edge.
  task automatic tick();
    int g;
    bit nb [NREG];
    logic [NREQ-1:0] exp_ready;
    #1;
    g = pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("rf_RegWrite", 64'(rf_RegWrite), 64'(m_we));
    chk("rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("rf_WriteData", rf_WriteData, m_data);
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1]));
    chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2]));
    nb = m_busy;
    if (m_we) nb[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    m_busy = nb;
    if (g >= 0) begin
      m_ptr  = FIXED ? 0 : (g + 1) % NREQ;
      m_gid  = g;
      m_rd   = bus.req_rd[g*AW +: AW];
      m_data = bus.req_data[g*XLEN +: XLEN];
      m_we   = (m_rd != 0);
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int g;
    reset = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = 5'd3; rs2 = 5'd0;
    bus.req_valid = '0; bus.req_rd = '0; bus.req_data = '0;
    set_req(0, 1'b1, 5'd1, 64'd10);
    set_req(1, 1'b1, 5'd2, 64'd25);
    model_reset();

    // Reset held with both requesters valid
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_we", 64'(rf_RegWrite), 64'd0);
    chk("rst_rs1_busy", 64'(rs1_busy), 64'd0);
    chk("rst_rs2_busy", 64'(rs2_busy), 64'd0);
    reset = 1'b1;
    #1;

    // Contention: alternating grants under round-robin, always req0 under fixed priority
    for (int k = 0; k < 4; k++) begin
      chk("cont_gnt", 64'(bus.req_ready), (FIXED || k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0) begin
        chk("cont_we", 64'(rf_RegWrite), 64'd1);
        chk("cont_rd", 64'(rf_rd), (FIXED || k % 2 == 1) ? 64'd1 : 64'd2);
      end
      tick();
    end

    // Zero register request still handshakes but never writes
    set_req(0, 1'b0, 5'd0, 64'd0);
    set_req(1, 1'b1, 5'd0, 64'd33);
    #1;
    chk("zero_ready", 64'(bus.req_ready), 64'd2);
    tick();
    set_req(1, 1'b0, 5'd0, 64'd0);
    chk("zero_we", 64'(rf_RegWrite), 64'd0);
    chk("zero_gid", 64'(grant_id), 64'd1);

    // Scoreboard set, then cleared the cycle after the rf write
    issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sb_set", 64'(rs1_busy), 64'd1);
    set_req(0, 1'b1, 5'd3, 64'd44);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0);
    chk("sb_we", 64'(rf_RegWrite), 64'd1);
    chk("sb_rd", 64'(rf_rd), 64'd3);
    chk("sb_data", rf_WriteData, 64'd44);
    chk("sb_still_busy", 64'(rs1_busy), 64'd1);
    tick();
    chk("sb_clear", 64'(rs1_busy), 64'd0);

    // Set and clear of the same register on one edge: set wins
    issue_valid = 1'b1; issue_rd = 5'd3;
    set_req(0, 1'b1, 5'd3, 64'd55);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0);
    chk("coll_we", 64'(rf_RegWrite), 64'd1);
    tick();
    issue_valid = 1'b0;
    chk("coll_busy", 64'(rs1_busy), 64'd1);

    // Asynchronous reset while a write is on the port
    issue_valid = 1'b1; issue_rd = 5'd7; rs2 = 5'd7;
    set_req(0, 1'b1, 5'd5, 64'd77);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0);
    issue_valid = 1'b0;
    #1;
    chk("ar_we_before", 64'(rf_RegWrite), 64'd1);
    chk("ar_busy_before", 64'(rs2_busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_we", 64'(rf_RegWrite), 64'd0);
    chk("ar_rd", 64'(rf_rd), 64'd0);
    chk("ar_data", rf_WriteData, 64'd0);
    chk("ar_busy", 64'(rs2_busy), 64'd0);
    chk("ar_busy3", 64'(rs1_busy), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic; a requester holds its request until granted
    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, 7));
      rs1         = AW'($urandom_range(0, 7));
      rs2         = AW'($urandom_range(0, 7));
      g = pick();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || i == g)
          set_req(i, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), {$urandom, $urandom});
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
